// File: rtl/border_draw_sequencer.sv
// rtl/border_draw_sequencer.sv - optional screen clear followed by a rectangular border draw
//
// Purpose: drives a 160x120 VGA pixel-write port. On a start request it optionally
// clears the whole screen to black, then plots the four edges of a rectangle
// (top, bottom, left, right) in a colour captured at start, then pulses done.
//
// Ports:
//   clk            clock, all state changes on posedge
//   reset          synchronous, active-low reset
//   start          sequence request, sampled only in IDLE
//   clear_en       sampled with start; 1 clears the full screen before the border
//   border_colour  sampled with start; colour of every border pixel
//   x, y, colour   registered pixel coordinate and colour, valid while plot=1
//   plot           write strobe, one pixel per cycle
//   busy           high in every state except IDLE
//   done           single-cycle pulse at the end of a sequence
module border_draw_sequencer #(
  parameter logic [7:0] X_MIN = 8'd15,
  parameter logic [7:0] X_MAX = 8'd140,
  parameter logic [6:0] Y_TOP = 7'd20,
  parameter logic [6:0] Y_BOT = 7'd105
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear_en,
  input  logic [2:0] border_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] SCR_X_LAST = 8'd159;
  localparam logic [6:0] SCR_Y_LAST = 7'd119;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    TOP    = 3'd2,
    BOTTOM = 3'd3,
    LEFT   = 3'd4,
    RIGHT  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state;
  logic [2:0] colour_lat;   // border colour captured at the start sample

  // Every output is registered and updated together with the state, so the
  // coordinate loaded on a transition is plotted in the first cycle of the new state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      colour_lat <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            colour_lat <= border_colour;
            plot       <= 1'b1;
            busy       <= 1'b1;
            if (clear_en) begin
              state  <= CLEAR;
              x      <= 8'd0;
              y      <= 7'd0;
              colour <= 3'd0;
            end else begin
              state  <= TOP;
              x      <= X_MIN;
              y      <= Y_TOP;
              colour <= border_colour;
            end
          end
        end

        CLEAR: begin
          if (x == SCR_X_LAST) begin
            if (y == SCR_Y_LAST) begin
              state  <= TOP;
              x      <= X_MIN;
              y      <= Y_TOP;
              colour <= colour_lat;
            end else begin
              x <= 8'd0;
              y <= y + 7'd1;
            end
          end else begin
            x <= x + 8'd1;
          end
        end

        TOP: begin
          if (x == X_MAX) begin
            state <= BOTTOM;
            x     <= X_MIN;
            y     <= Y_BOT;
          end else begin
            x <= x + 8'd1;
          end
        end

        BOTTOM: begin
          if (x == X_MAX) begin
            state <= LEFT;
            x     <= X_MIN;
            y     <= Y_TOP;
          end else begin
            x <= x + 8'd1;
          end
        end

        LEFT: begin
          if (y == Y_BOT) begin
            state <= RIGHT;
            x     <= X_MAX;
            y     <= Y_TOP;
          end else begin
            y <= y + 7'd1;
          end
        end

        RIGHT: begin
          if (y == Y_BOT) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            y <= y + 7'd1;
          end
        end

        // start is deliberately not looked at here; a request must be seen in IDLE.
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_border_draw_sequencer.sv
// tb/tb_border_draw_sequencer.sv - self-checking bench for border_draw_sequencer
module tb_border_draw_sequencer;

  localparam int XMIN = 15;
  localparam int XMAX = 140;
  localparam int YTOP = 20;
  localparam int YBOT = 105;
  localparam int EDGE_H = XMAX - XMIN + 1;   // 126
  localparam int EDGE_V = YBOT - YTOP + 1;   // 86
  localparam int CLR_N  = 160 * 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       clear_en = 1'b0;
  logic [2:0] border_colour = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  border_draw_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .clear_en(clear_en),
    .border_colour(border_colour), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  px_t exp_q[$];
  int  hits [160][120];
  int  first_x, first_y, last_x, last_y;

  // Reference pixel stream built straight from the drawing rules.
  function automatic void build(input bit clr, input int col);
    exp_q.delete();
    if (clr)
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++) exp_q.push_back('{xx, yy, 0});
    for (int xx = XMIN; xx <= XMAX; xx++) exp_q.push_back('{xx, YTOP, col});
    for (int xx = XMIN; xx <= XMAX; xx++) exp_q.push_back('{xx, YBOT, col});
    for (int yy = YTOP; yy <= YBOT; yy++) exp_q.push_back('{XMIN, yy, col});
    for (int yy = YTOP; yy <= YBOT; yy++) exp_q.push_back('{XMAX, yy, col});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: inputs scrambled after the start sample
  // mode 1: extra start pulses mid-TOP and in the DONE cycle
  // mode 2: border_colour switched to 1 partway through LEFT
  task automatic run_seq(input string tag, input bit clr, input logic [2:0] col, input int mode);
    int idx, pix_err, done_cnt, done_cyc, busy_err, off, n;
    px_t e;
    build(clr, int'(col));
    n = exp_q.size();
    off = clr ? CLR_N : 0;
    foreach (hits[i, j]) hits[i][j] = 0;
    idx = 0; pix_err = 0; done_cnt = 0; done_cyc = -1; busy_err = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    start = 1'b1; clear_en = clr; border_colour = col;
    tick();
    for (int cyc = 1; cyc <= n + 3; cyc++) begin
      start = 1'b0;
      if (mode == 2) begin
        clear_en = 1'b0;
        border_colour = (idx >= off + 2 * EDGE_H + 40) ? 3'd1 : col;
      end else begin
        clear_en = 1'($urandom);
        border_colour = 3'($urandom);
      end
      if (mode == 1 && idx == off + 60) start = 1'b1;
      if (plot === 1'b1) begin
        if (idx < n) begin
          e = exp_q[idx];
          if (int'(x) != e.x || int'(y) != e.y || int'(colour) != e.c) pix_err++;
        end else pix_err++;
        if (x < 8'd160 && y < 7'd120 && idx >= off) hits[x][y]++;
        if (idx == off) begin first_x = int'(x); first_y = int'(y); end
        last_x = int'(x); last_y = int'(y);
        idx++;
      end
      if (done_cyc < 0 && busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (plot !== 1'b0 || busy !== 1'b1) busy_err++;
        if (mode == 1) start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_pixels"}, pix_err, 0);
    chk({tag, "_plot_count"}, idx, n);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, n + 1);
    chk({tag, "_busy_flags"}, busy_err, 0);
    chk({tag, "_idle_after"}, int'({busy, plot, done}), 0);
  endtask

  typedef struct {
    bit         clr;
    logic [2:0] col;
    int         ex1, ey1, ec1;
    int         ex2;
  } vec_t;

  vec_t tv[4];
  int   err, want, rx, ry, guard;

  initial begin
    tv[0] = '{1'b0, 3'd5, XMIN, YTOP, 5, XMIN + 1};
    tv[1] = '{1'b1, 3'd3, 0, 0, 0, 1};
    tv[2] = '{1'b0, 3'd0, XMIN, YTOP, 0, XMIN + 1};
    tv[3] = '{1'b1, 3'd7, 0, 0, 0, 1};

    // Reset state and first two pixels of each entry point.
    for (int i = 0; i < 4; i++) begin
      reset = 1'b0;
      start = 1'b1;
      tick();
      chk($sformatf("v%0d_reset_state", i), int'({x, y, colour, plot, busy, done}), 0);
      reset = 1'b1;
      clear_en = tv[i].clr;
      border_colour = tv[i].col;
      tick();
      start = 1'b0;
      border_colour = ~tv[i].col;
      chk($sformatf("v%0d_first_xy", i), int'(x) * 256 + int'(y), tv[i].ex1 * 256 + tv[i].ey1);
      chk($sformatf("v%0d_first_colour", i), int'(colour), tv[i].ec1);
      chk($sformatf("v%0d_first_strobes", i), int'({plot, busy, done}), 3'b110);
      tick();
      chk($sformatf("v%0d_second_x", i), int'(x), tv[i].ex2);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // No-clear run with perimeter scoreboard.
    run_seq("noclr7", 1'b0, 3'd7, 0);
    chk("noclr7_first", first_x * 256 + first_y, XMIN * 256 + YTOP);
    chk("noclr7_last", last_x * 256 + last_y, XMAX * 256 + YBOT);
    err = 0;
    for (int xx = 0; xx < 160; xx++)
      for (int yy = 0; yy < 120; yy++) begin
        want = 0;
        if (xx >= XMIN && xx <= XMAX && (yy == YTOP || yy == YBOT)) want += (yy == YTOP && yy == YBOT) ? 2 : 1;
        if (yy >= YTOP && yy <= YBOT && (xx == XMIN || xx == XMAX)) want += 1;
        if (hits[xx][yy] != want) err++;
      end
    chk("perimeter_scoreboard", err, 0);
    chk("corner_hits", hits[XMIN][YTOP] + hits[XMAX][YTOP] + hits[XMIN][YBOT] + hits[XMAX][YBOT], 8);

    run_seq("clr2", 1'b1, 3'd2, 0);
    run_seq("restart_ignored", 1'b0, 3'd4, 1);
    run_seq("colour_mid_left", 1'b0, 3'd7, 2);

    // Randomized border-only runs.
    for (int r = 0; r < 4; r++)
      run_seq($sformatf("rand%0d", r), 1'b0, 3'($urandom), int'($urandom_range(0, 1)));

    // start held through DONE into IDLE launches a fresh sequence.
    start = 1'b1; clear_en = 1'b0; border_colour = 3'd6;
    guard = 0;
    tick();
    while (done !== 1'b1 && guard < 600) begin tick(); guard++; end
    chk("held_start_reached_done", int'(done), 1);
    tick();
    chk("held_start_idle_cycle", int'({busy, plot}), 0);
    tick();
    chk("held_start_relaunch", int'({plot, busy}) * 65536 + int'(x) * 256 + int'(y), 3 * 65536 + XMIN * 256 + YTOP);
    start = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Reset in the middle of a clear.
    start = 1'b1; clear_en = 1'b1; border_colour = 3'd5;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(plot === 1'b1 && x == 8'd80 && y == 7'd60) && guard < 20000) begin tick(); guard++; end
    chk("reset_reached_80_60", int'(x) * 256 + int'(y), 80 * 256 + 60);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("reset_abort_outputs", int'({x, y, colour, plot, busy, done}), 0);
    err = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) err++;
    end
    chk("reset_abort_quiet", err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
